sponge_padder: RTL
==================

SPONGE_PADDER -- requirements
Module: sponge_padder

Interface
REQ-001 SHALL have parameter RATE_BYTES, default 136, meaning sponge rate in bytes (1088-bit rate, 512-bit capacity).
REQ-002 SHALL have parameter DS, default 8'h1F, meaning domain-separation suffix byte (SHAKE).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, 8 bits, message byte.
REQ-006 SHALL have port in_valid, input, 1 bit, in_data/in_last/in_empty valid.
REQ-007 SHALL have port in_last, input, 1 bit, beat is final beat of message.
REQ-008 SHALL have port in_empty, input, 1 bit, qualifies a last beat as carrying no byte (used for empty messages or late last-marking); ignored when in_last=0.
REQ-009 SHALL have port in_ready, output, 1 bit, padder accepts a beat this cycle.
REQ-010 SHALL have port blk_data, output, RATE_BYTES*8 bits, rate block; byte i at bits [8i+7:8i].
REQ-011 SHALL have port blk_valid, output, 1 bit, blk_data is a complete block for the sponge absorb stage.
REQ-012 SHALL have port blk_ready, input, 1 bit, downstream sponge accepts block.
REQ-013 SHALL have port blk_last, output, 1 bit, block is the final (padded) block of the message.

Function
REQ-014 SHALL implement states FILL, EMIT, EXTRA; a beat transfers when in_valid&in_ready, a block when blk_valid&blk_ready.
REQ-015 SHALL drive in_ready=1 only in FILL; blk_valid=1 only in EMIT.
REQ-016 SHALL, in FILL, write an accepted non-empty byte to buffer index cnt and increment cnt (0..RATE_BYTES-1).
REQ-017 SHALL, on a non-last byte that makes cnt reach RATE_BYTES, enter EMIT with blk_last=0 next cycle.
REQ-018 SHALL, on a last beat leaving k bytes in buffer with k<RATE_BYTES, XOR DS into byte k and 8'h80 into byte RATE_BYTES-1 (k=RATE_BYTES-1 gives 8'h9F), enter EMIT with blk_last=1 next cycle.
REQ-019 SHALL, on a last beat leaving k=RATE_BYTES, enter EMIT with blk_last=0 and flag an extra block pending.
REQ-020 SHALL, on block handshake in EMIT, clear buffer to zero and cnt to 0; go to EXTRA if extra pending, else FILL.
REQ-021 SHALL, in EXTRA, load buffer with byte0=DS, byte RATE_BYTES-1=8'h80, rest 0, clear pending flag, enter EMIT with blk_last=1 next cycle.
REQ-022 SHALL assert blk_valid the cycle after the completing beat; latency from final beat to blk_valid is 1 cycle (2 extra cycles after first block handshake for the extra block).
REQ-023 SHALL hold blk_data, blk_last and blk_valid stable while blk_valid=1 and blk_ready=0.
REQ-024 SHALL ignore in_data whenever in_ready=0 or the beat is last with in_empty=1.
REQ-025 SHALL support back-to-back messages: next message's first beat accepted in the first FILL cycle after the final block handshake.

Reset
REQ-026 SHALL, on reset assertion at any time (including mid-fill or mid-EMIT), immediately enter FILL, zero buffer, cnt=0, clear pending flag; outputs blk_valid=0, blk_last=0, blk_data=0, in_ready=1 after reset deasserts.
REQ-027 SHALL discard any partial message on reset; no block is emitted for it.

Verification
REQ-028 SHALL cover: one byte 8'h13 last, blk_ready=1 -> one block, byte0=8'h13, byte1=8'h1F, byte135=8'h80, others 0, blk_last=1, blk_valid 1 cycle after beat.
REQ-029 SHALL cover: single beat in_last=1,in_empty=1 -> one block byte0=8'h1F, byte135=8'h80, blk_last=1.
REQ-030 SHALL cover: 135 bytes 8'hAA last -> bytes 0..134=8'hAA, byte135=8'h9F, blk_last=1.
REQ-031 SHALL cover: 136 bytes 8'h55 last -> block A all 8'h55 blk_last=0, then block B byte0=8'h1F, byte135=8'h80, blk_last=1; no beats accepted between.
REQ-032 SHALL cover: blk_ready held 0 for 10 cycles during EMIT -> blk_data/blk_last/blk_valid unchanged, in_ready=0 throughout, single handshake on release.
REQ-033 SHALL cover: reset asserted after 50 bytes -> in_ready=1, blk_valid=0 next cycle; following 1-byte message 8'h01 yields byte0=8'h01, byte1=8'h1F, byte135=8'h80 only.

Source files
------------

// File: rtl/sponge_padder.sv
// Sponge message padder: packs a byte stream into RATE_BYTES-wide rate blocks
// and applies the domain-separation suffix plus the final 0x80 pad bit.

module sponge_padder_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr,
  input  logic [7:0] d,
  input  logic [7:0] x,
  output logic [7:0] q
);
  // Clear/write selects the base value; the pad mask is XORed on top so a
  // clear plus mask loads the standalone padding block in one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 8'h00;
    else       q <= (clr ? 8'h00 : (wr ? d : q)) ^ x;
  end
endmodule

module sponge_padder #(
  parameter int         RATE_BYTES = 136,
  parameter logic [7:0] DS         = 8'h1F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic                    in_empty,
  output logic                    in_ready,
  output logic [RATE_BYTES*8-1:0] blk_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    blk_last
);
  localparam int CW = $clog2(RATE_BYTES + 1);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            pend;

  logic            acc, has_byte, pad_en, hs, clr, in_extra;
  logic [CW-1:0]   k;
  logic [RATE_BYTES-1:0][7:0] bytes;

  assign acc      = in_valid & in_ready & (state == FILL);
  assign has_byte = ~(in_last & in_empty);
  assign k        = cnt + CW'(has_byte);
  // Padding fits into the current block only when the message leaves room.
  assign pad_en   = acc & in_last & (k != CW'(RATE_BYTES));
  assign hs       = blk_valid & blk_ready;
  assign in_extra = (state == EXTRA);
  assign clr      = hs | in_extra;
  assign blk_data = bytes;

  for (genvar i = 0; i < RATE_BYTES; i++) begin : g_lane
    logic       wr;
    logic [7:0] x;

    assign wr = acc & has_byte & (cnt == CW'(i));
    assign x  = ((pad_en && (k == CW'(i)))             ? DS    : 8'h00)
              ^ ((pad_en && (i == RATE_BYTES - 1))     ? 8'h80 : 8'h00)
              ^ ((in_extra && (i == 0))                ? DS    : 8'h00)
              ^ ((in_extra && (i == RATE_BYTES - 1))   ? 8'h80 : 8'h00);

    sponge_padder_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .wr    (wr),
      .d     (in_data),
      .x     (x),
      .q     (bytes[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      cnt       <= '0;
      pend      <= 1'b0;
      in_ready  <= 1'b1;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (acc) begin
            cnt <= k;
            if (in_last || (k == CW'(RATE_BYTES))) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              blk_valid <= 1'b1;
              blk_last  <= pad_en;
              // A full block ending the message needs a separate pad block.
              pend      <= in_last & ~pad_en;
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            cnt       <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            if (pend) begin
              state <= EXTRA;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end
        EXTRA: begin
          pend      <= 1'b0;
          state     <= EMIT;
          blk_valid <= 1'b1;
          blk_last  <= 1'b1;
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
